// File: rtl/imem_dmem_arbiter_if.sv
// Fetch, load/store and unified-memory signals of the shared-memory arbiter.
// slave is the arbiter's view; master is the CPU/memory side driving it.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store; data wins ties, starvation counter forces fetch.
// Grant is combinational; response one cycle after mem_rdata sampling (MEM_LAT+1); requests held off while busy.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_dmem_arbiter_if.slave  bus
);
    localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int STARVE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                owner_dm;
    logic                owner_we;
    logic                grant_if;
    logic                grant_dm;
    logic                if_rvalid_q;
    logic                dm_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    // Gating with rst keeps every issue output at 0 while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (rst && state == IDLE) begin
            if (bus.dm_req && !(bus.if_req && starve_cnt == STARVE_W'(STARVE_MAX)))
                grant_dm = 1'b1;
            else if (bus.if_req)
                grant_if = 1'b1;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dm_gnt    = grant_dm;
    assign bus.mem_en    = grant_if | grant_dm;
    assign bus.mem_we    = grant_dm & bus.dm_we;
    assign bus.mem_addr  = grant_dm ? bus.dm_addr : (grant_if ? bus.if_addr : '0);
    assign bus.mem_wdata = grant_dm ? bus.dm_wdata : '0;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            owner_dm    <= 1'b0;
            owner_we    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;

            // Counts only grants lost by a waiting fetch.
            if (!bus.if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_dm && starve_cnt != STARVE_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + STARVE_W'(1);

            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        state    <= BUSY;
                        lat_cnt  <= LAT_W'(MEM_LAT);
                        owner_dm <= grant_dm;
                        owner_we <= grant_dm & bus.dm_we;
                    end
                end
                BUSY: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                        if (owner_dm) begin
                            dm_rvalid_q <= 1'b1;
                            dm_rdata_q  <= owner_we ? '0 : bus.mem_rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a two-cycle memory stub.
// Inputs change and outputs are checked just after the falling edge.
module tb_imem_dmem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: data for the issued address appears exactly two cycles later, junk otherwise.
    logic        v1, v2;
    logic [31:0] a1, a2;
    always @(posedge clk) begin
        v1 <= bus.mem_en;
        a1 <= bus.mem_addr;
        v2 <= v1;
        a2 <= a1;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00A00593 : (a ^ 32'h5A5A0000);
    endfunction

    assign bus.mem_rdata = v2 ? mem_val(a2) : 32'hBADBAD00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    bit win_dm [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    initial begin
        checks   = 0;
        failures = 0;
        v1 = 0; v2 = 0; a1 = 0; a2 = 0;
        rst = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h200;
        bus.dm_wdata = 32'h11112222;

        // Reset held with both requests pending.
        repeat (3) begin
            tick(); #1;
            chk("rst_ctl", {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.mem_we}, 64'd0);
            chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'd0);
            chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'd0);
        end

        // First cycle after release: data wins the tie.
        tick(); rst = 1'b1; #1;
        chk("rel_gnt", {bus.if_gnt, bus.dm_gnt, bus.mem_en}, 64'b011);
        chk("rel_addr", bus.mem_addr, 64'h200);
        tick(); bus.if_req = 1'b0; bus.dm_req = 1'b0; #1;
        chk("rel_busy", {bus.if_gnt, bus.dm_gnt, bus.mem_en}, 64'd0);
        tick(); #1;
        chk("rel_t2_rv", bus.dm_rvalid, 64'd0);
        tick(); #1;
        chk("rel_t3_rv", {bus.if_rvalid, bus.dm_rvalid}, 64'b01);
        chk("rel_t3_rd", bus.dm_rdata, 64'h5A5A0200);

        // Single fetch; wdata nonzero to prove fetch issues mem_wdata = 0.
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.dm_wdata = 32'hCAFEF00D; #1;
        chk("if_gnt", {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we}, 64'b1010);
        chk("if_mem", {bus.mem_addr, bus.mem_wdata}, {32'h40, 32'h0});
        tick(); bus.if_req = 1'b0; #1;
        chk("if_t1", {bus.if_gnt, bus.if_rvalid}, 64'd0);
        tick(); #1;
        chk("if_t2", bus.if_rvalid, 64'd0);
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h44; #1;
        chk("if_t3_rv", {bus.if_rvalid, bus.dm_rvalid}, 64'b10);
        chk("if_t3_rd", bus.if_rdata, 64'h00A00593);
        chk("if_t3_regnt", {bus.if_gnt, bus.mem_addr}, {1'b1, 32'h44});
        tick(); bus.if_req = 1'b0; #1;
        chk("if_hold", {bus.if_rvalid, bus.if_rdata}, {1'b0, 32'h00A00593});
        tick(); tick(); #1;
        chk("if2_rd", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h5A5A0044});

        // Simultaneous requests from starve_cnt = 0.
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.dm_req = 1'b1; bus.dm_addr = 32'h300; #1;
        chk("sim_gnt", {bus.if_gnt, bus.dm_gnt}, 64'b01);
        tick(); bus.dm_req = 1'b0; #1;
        chk("sim_busy", bus.mem_en, 64'd0);
        tick(); tick(); #1;
        chk("sim_dm_rv", {bus.dm_rvalid, bus.dm_rdata}, {1'b1, 32'h5A5A0300});
        chk("sim_if_gnt", {bus.if_gnt, bus.dm_gnt, bus.mem_addr}, {2'b10, 32'h80});
        tick(); bus.if_req = 1'b0; tick(); tick(); #1;
        chk("sim_if_rv", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h5A5A0080});

        // Starvation: both held high; fetch forced every fifth grant.
        for (int k = 0; k < 11; k++) begin
            tick();
            if (k == 0) begin
                bus.if_req = 1'b1; bus.if_addr = 32'hC0;
                bus.dm_req = 1'b1; bus.dm_addr = 32'h400;
            end
            #1;
            chk($sformatf("stv_gnt%0d", k), {bus.if_gnt, bus.dm_gnt}, win_dm[k] ? 64'b01 : 64'b10);
            chk($sformatf("stv_addr%0d", k), bus.mem_addr, win_dm[k] ? 64'h400 : 64'hC0);
            if (k > 0) begin
                if (win_dm[k-1])
                    chk($sformatf("stv_rv%0d", k), {bus.if_rvalid, bus.dm_rvalid, bus.dm_rdata}, {2'b01, 32'h5A5A0400});
                else
                    chk($sformatf("stv_rv%0d", k), {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata}, {2'b10, 32'h5A5A00C0});
            end
            tick();
            if (k == 10) begin
                bus.if_req = 1'b0; bus.dm_req = 1'b0;
            end
            #1;
            chk($sformatf("stv_busy%0d", k), bus.mem_en, 64'd0);
            tick();
        end
        tick(); #1;
        chk("stv_last_rv", {bus.dm_rvalid, bus.dm_rdata}, {1'b1, 32'h5A5A0400});

        // Reset in the middle of a load.
        tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500; #1;
        chk("mid_gnt", {bus.dm_gnt, bus.mem_addr}, {1'b1, 32'h500});
        tick(); rst = 1'b0; bus.dm_addr = 32'h600; #1;
        chk("mid_rst_ctl", {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.if_rvalid, bus.dm_rvalid}, 64'd0);
        chk("mid_rst_rd", {bus.if_rdata, bus.dm_rdata}, 64'd0);
        tick(); rst = 1'b1; #1;
        chk("mid_regnt", {bus.dm_gnt, bus.mem_addr}, {1'b1, 32'h600});
        tick(); bus.dm_req = 1'b0; #1;
        chk("mid_stale3", bus.dm_rvalid, 64'd0);
        tick(); #1;
        chk("mid_stale4", bus.dm_rvalid, 64'd0);
        tick(); #1;
        chk("mid_new_rv", {bus.dm_rvalid, bus.dm_rdata}, {1'b1, 32'h5A5A0600});

        // Store: memory stub returns nonzero data, dm_rdata must still be 0.
        tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF; #1;
        chk("st_ctl", {bus.dm_gnt, bus.mem_en, bus.mem_we}, 64'b111);
        chk("st_mem", {bus.mem_addr, bus.mem_wdata}, {32'h100, 32'hDEADBEEF});
        tick(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; #1;
        chk("st_t1", {bus.dm_rvalid, bus.mem_en}, 64'd0);
        tick(); #1;
        chk("st_t2", bus.dm_rvalid, 64'd0);
        tick(); #1;
        chk("st_t3", {bus.if_rvalid, bus.dm_rvalid, bus.dm_rdata}, {2'b01, 32'h0});
        tick(); #1;
        chk("st_t4", {bus.if_rvalid, bus.dm_rvalid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
